// File: rtl/div_scheduler_if.sv
// Handshake bundle between EX/WB and the divide scheduler, plus the
// iterative divider datapath hookup.
`timescale 1ns/1ps
interface div_scheduler_if;
    logic        issue_valid_i;
    logic [1:0]  issue_op_i;
    logic [4:0]  issue_rd_i;
    logic [31:0] issue_a_i;
    logic [31:0] issue_b_i;
    logic        overlap_ok_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        div_start_o;
    logic        div_signed_o;
    logic [31:0] div_a_o;
    logic [31:0] div_b_o;
    logic [31:0] div_q_i;
    logic [31:0] div_r_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        wb_ready_i;

    modport slave (
        input  issue_valid_i, issue_op_i, issue_rd_i, issue_a_i, issue_b_i,
        input  overlap_ok_i, flush_i, div_q_i, div_r_i, wb_ready_i,
        output stall_o, busy_o, div_start_o, div_signed_o, div_a_o, div_b_o,
        output wb_valid_o, wb_rd_o, wb_data_o
    );

    modport master (
        output issue_valid_i, issue_op_i, issue_rd_i, issue_a_i, issue_b_i,
        output overlap_ok_i, flush_i, div_q_i, div_r_i, wb_ready_i,
        input  stall_o, busy_o, div_start_o, div_signed_o, div_a_o, div_b_o,
        input  wb_valid_o, wb_rd_o, wb_data_o
    );
endinterface

// File: rtl/div_scheduler.sv
// Sequences M-extension divide/remainder ops onto an iterative divider,
// with one pending slot and a valid/ready writeback port.
//   state | meaning
//   IDLE  | nothing in flight
//   RUN   | datapath busy, down-counter running
//   DONE  | result held on the writeback port until accepted
`timescale 1ns/1ps
module div_scheduler #(
    parameter int DIV_LAT = 32
) (
    input logic      clk,
    input logic      rst,
    div_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [5:0] CNT_LOAD = 6'(DIV_LAT - 1);

    state_t      state, state_next;
    logic        pend_valid;
    logic [1:0]  pend_op;
    logic [4:0]  pend_rd;
    logic [31:0] pend_a, pend_b;
    logic [1:0]  cur_op;
    logic [5:0]  cnt;
    logic [31:0] res;
    logic [4:0]  res_rd;
    logic        div_start, div_signed;
    logic [31:0] div_a, div_b;

    logic        accept, retire, use_pend, do_start, pend_set;
    logic [1:0]  s_op;
    logic [4:0]  s_rd;
    logic [31:0] s_a, s_b, s_fast_res;
    logic        s_fast;

    assign bus.stall_o = bus.issue_valid_i & ~bus.flush_i & (state != IDLE)
                       & (pend_valid | ~bus.overlap_ok_i);
    assign accept   = bus.issue_valid_i & ~bus.flush_i & ~bus.stall_o;
    assign retire   = (state == DONE) & bus.wb_ready_i;
    // A flush in the retire cycle kills the pending op before it can start.
    assign use_pend = retire & pend_valid & ~bus.flush_i;

    assign bus.busy_o       = (state != IDLE) | pend_valid;
    assign bus.wb_valid_o   = (state == DONE);
    assign bus.wb_rd_o      = res_rd;
    assign bus.wb_data_o    = res;
    assign bus.div_start_o  = div_start;
    assign bus.div_signed_o = div_signed;
    assign bus.div_a_o      = div_a;
    assign bus.div_b_o      = div_b;

    always_comb begin
        s_op = use_pend ? pend_op : bus.issue_op_i;
        s_rd = use_pend ? pend_rd : bus.issue_rd_i;
        s_a  = use_pend ? pend_a  : bus.issue_a_i;
        s_b  = use_pend ? pend_b  : bus.issue_b_i;
    end

    // Divide-by-zero and signed overflow never touch the datapath.
    always_comb begin
        s_fast     = 1'b0;
        s_fast_res = 32'h0;
        if (s_b == 32'h0) begin
            s_fast     = 1'b1;
            s_fast_res = s_op[1] ? s_a : 32'hFFFF_FFFF;
        end else if (!s_op[0] && s_a == 32'h8000_0000 && s_b == 32'hFFFF_FFFF) begin
            s_fast     = 1'b1;
            s_fast_res = s_op[1] ? 32'h0 : 32'h8000_0000;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_start   = 1'b0;
        pend_set   = 1'b0;
        case (state)
            IDLE: if (accept) do_start = 1'b1;
            RUN: begin
                if (accept) pend_set = 1'b1;
                if (cnt == 6'd0) state_next = DONE;
            end
            DONE: begin
                if (retire) begin
                    if (use_pend || accept) do_start = 1'b1;
                    else                    state_next = IDLE;
                end else if (accept) begin
                    pend_set = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (do_start) state_next = s_fast ? DONE : RUN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid <= 1'b0;
            pend_op    <= 2'b00;
            pend_rd    <= 5'd0;
            pend_a     <= 32'h0;
            pend_b     <= 32'h0;
        end else if (bus.flush_i || use_pend) begin
            pend_valid <= 1'b0;
        end else if (pend_set) begin
            pend_valid <= 1'b1;
            pend_op    <= bus.issue_op_i;
            pend_rd    <= bus.issue_rd_i;
            pend_a     <= bus.issue_a_i;
            pend_b     <= bus.issue_b_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_op     <= 2'b00;
            cnt        <= 6'd0;
            res        <= 32'h0;
            res_rd     <= 5'd0;
            div_start  <= 1'b0;
            div_signed <= 1'b0;
            div_a      <= 32'h0;
            div_b      <= 32'h0;
        end else begin
            div_start <= do_start & ~s_fast;
            if (do_start) begin
                cur_op <= s_op;
                res_rd <= s_rd;
                if (s_fast) begin
                    res <= s_fast_res;
                end else begin
                    div_a      <= s_a;
                    div_b      <= s_b;
                    div_signed <= ~s_op[0];
                    cnt        <= CNT_LOAD;
                end
            end else if (state == RUN) begin
                if (cnt == 6'd0) res <= cur_op[1] ? bus.div_r_i : bus.div_q_i;
                else             cnt <= cnt - 6'd1;
            end
        end
    end
endmodule

// File: tb/tb_div_scheduler.sv
// Self-checking bench for div_scheduler: directed latency/corner scenarios
// plus randomized traffic against an in-order result scoreboard.
`timescale 1ns/1ps
module tb_div_scheduler;
    localparam int DIV_LAT = 32;
    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    div_scheduler_if bus();
    div_scheduler #(.DIV_LAT(DIV_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // RISC-V divide semantics from plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (b == 32'h0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    // Datapath stand-in: result appears the cycle after the start pulse and
    // holds a poison value until the first start.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.div_q_i <= 32'hDEAD_BEEF;
            bus.div_r_i <= 32'hDEAD_BEEF;
        end else if (bus.div_start_o === 1'b1) begin
            bus.div_q_i <= ref_result({1'b0, ~bus.div_signed_o}, bus.div_a_o, bus.div_b_o);
            bus.div_r_i <= ref_result({1'b1, ~bus.div_signed_o}, bus.div_a_o, bus.div_b_o);
        end
    end

    function automatic logic [105:0] all_outs();
        return {bus.stall_o, bus.busy_o, bus.div_start_o, bus.div_signed_o, bus.div_a_o,
                bus.div_b_o, bus.wb_valid_o, bus.wb_rd_o, bus.wb_data_o};
    endfunction

    task automatic drive(input bit v, input logic [1:0] op, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b);
        bus.issue_valid_i = v;
        bus.issue_op_i    = op;
        bus.issue_rd_i    = rd;
        bus.issue_a_i     = a;
        bus.issue_b_i     = b;
    endtask

    task automatic wait_wb(input int budget, output int n, output logic [4:0] rd,
                           output logic [31:0] data, output bit ok);
        ok = 0; n = 0; rd = 0; data = 0;
        for (int c = 1; c <= budget && !ok; c++) begin
            @(negedge clk);
            n = c;
            if (bus.wb_valid_o === 1'b1 && bus.wb_ready_i === 1'b1) begin
                ok = 1; rd = bus.wb_rd_o; data = bus.wb_data_o;
            end
        end
    endtask

    task automatic test_reset;
        drive(0, 2'b00, 5'd0, 32'h0, 32'h0);
        bus.overlap_ok_i = 1'b1; bus.flush_i = 1'b0; bus.wb_ready_i = 1'b1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 106'h0) begin errors++; $display("FAIL reset_outs got=%h exp=0", all_outs()); end
        repeat (2) @(negedge clk);
        checks++;
        if (all_outs() !== 106'h0) begin errors++; $display("FAIL reset_hold got=%h exp=0", all_outs()); end
        rst = 1'b1;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [4:0] rd, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [31:0] exp_data,
                          input string nm);
        int lat, starts;
        bit seen;
        bus.wb_ready_i = 1'b1; bus.overlap_ok_i = 1'b1; bus.flush_i = 1'b0;
        @(posedge clk); #1;
        drive(1, op, rd, a, b);
        @(negedge clk);
        checks++;
        if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL %s_accept stall=%b exp=0", nm, bus.stall_o); end
        @(posedge clk); #1;
        drive(0, op, rd, a, b);
        seen = 0; lat = 0; starts = 0;
        for (int c = 1; c <= DIV_LAT + 10 && !seen; c++) begin
            @(negedge clk);
            if (bus.div_start_o === 1'b1) begin
                starts++;
                checks++;
                if ({bus.div_a_o, bus.div_b_o, bus.div_signed_o} !== {a, b, ~op[0]} || c != 1) begin
                    errors++;
                    $display("FAIL %s_start cyc=%0d a=%h b=%h sgn=%b exp cyc=1 a=%h b=%h sgn=%b",
                             nm, c, bus.div_a_o, bus.div_b_o, bus.div_signed_o, a, b, ~op[0]);
                end
            end
            if (bus.wb_valid_o === 1'b1) begin seen = 1; lat = c; end
        end
        checks++;
        if (!seen || lat != exp_lat) begin errors++; $display("FAIL %s_latency got=%0d exp=%0d", nm, lat, exp_lat); end
        checks++;
        if ({bus.wb_rd_o, bus.wb_data_o} !== {rd, exp_data}) begin
            errors++; $display("FAIL %s_result rd=%0d data=%h exp rd=%0d data=%h", nm, bus.wb_rd_o, bus.wb_data_o, rd, exp_data);
        end
        checks++;
        if (starts != ((exp_lat == 1) ? 0 : 1)) begin
            errors++; $display("FAIL %s_start_count got=%0d exp=%0d", nm, starts, (exp_lat == 1) ? 0 : 1);
        end
        @(negedge clk);
        checks++;
        if ({bus.wb_valid_o, bus.busy_o} !== 2'b00) begin
            errors++; $display("FAIL %s_idle valid=%b busy=%b exp 0 0", nm, bus.wb_valid_o, bus.busy_o);
        end
    endtask

    task automatic test_div_rem;
        run_op(OP_DIV, 5'd5, 32'd100, 32'd7, DIV_LAT + 1, 32'd14, "div_100_7");
        run_op(OP_REM, 5'd5, 32'd100, 32'd7, DIV_LAT + 1, 32'd2, "rem_100_7");
        run_op(OP_DIV, 5'd0, 32'hFFFF_FF9C, 32'd7, DIV_LAT + 1, 32'hFFFF_FFF2, "div_neg_rd0");
        run_op(OP_REMU, 5'd9, 32'hFFFF_FF9C, 32'd7, DIV_LAT + 1, ref_result(OP_REMU, 32'hFFFF_FF9C, 32'd7), "remu_big");
    endtask

    task automatic test_fast;
        run_op(OP_DIVU, 5'd3, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, "divu_by_zero");
        run_op(OP_REMU, 5'd3, 32'd5, 32'd0, 1, 32'd5, "remu_by_zero");
        run_op(OP_DIV, 5'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, "div_overflow");
        run_op(OP_REM, 5'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, "rem_overflow");
        run_op(OP_DIVU, 5'd4, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT + 1, 32'h0, "divu_no_overflow");
    endtask

    task automatic test_back_to_back;
        int first_free, a_cyc, cyc, n, cnt;
        logic [4:0]  rd, a_rd;
        logic [31:0] d, a_d;
        bit ok, done;
        bus.overlap_ok_i = 1'b1; bus.wb_ready_i = 1'b1; bus.flush_i = 1'b0;
        @(posedge clk); #1; drive(1, OP_DIV, 5'd1, 32'd1000, 32'd3);
        @(negedge clk);
        checks++;
        if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL b2b_first stall=%b exp=0", bus.stall_o); end
        @(posedge clk); #1; drive(1, OP_DIVU, 5'd2, 32'd77777, 32'd5);
        @(negedge clk);
        checks++;
        if ({bus.stall_o, bus.busy_o} !== 2'b01) begin errors++; $display("FAIL b2b_pending stall=%b busy=%b exp 0 1", bus.stall_o, bus.busy_o); end
        @(posedge clk); #1; drive(1, OP_REM, 5'd3, 32'hFFFF_FFCE, 32'd7);
        first_free = -1; a_cyc = -1; a_rd = 0; a_d = 0;
        for (int c = 2; c <= DIV_LAT + 10 && first_free < 0; c++) begin
            @(negedge clk);
            if (bus.wb_valid_o === 1'b1) begin a_cyc = c; a_rd = bus.wb_rd_o; a_d = bus.wb_data_o; end
            if (bus.stall_o === 1'b0) first_free = c;
        end
        checks++;
        if (a_cyc != DIV_LAT + 1 || {a_rd, a_d} !== {5'd1, 32'd333}) begin
            errors++; $display("FAIL b2b_first_result cyc=%0d rd=%0d data=%h exp cyc=%0d rd=1 data=%h", a_cyc, a_rd, a_d, DIV_LAT + 1, 32'd333);
        end
        checks++;
        if (first_free != DIV_LAT + 2) begin errors++; $display("FAIL b2b_third_stall free_cyc=%0d exp=%0d", first_free, DIV_LAT + 2); end
        @(posedge clk); #1; drive(0, OP_DIV, 5'd0, 32'h0, 32'h0);
        cyc = first_free;
        wait_wb(2 * DIV_LAT, n, rd, d, ok); cyc += n;
        checks++;
        if (!ok || cyc != 2 * DIV_LAT + 2 || {rd, d} !== {5'd2, 32'd15555}) begin
            errors++; $display("FAIL b2b_second cyc=%0d rd=%0d data=%h exp cyc=%0d rd=2 data=%h", cyc, rd, d, 2 * DIV_LAT + 2, 32'd15555);
        end
        wait_wb(2 * DIV_LAT, n, rd, d, ok); cyc += n;
        checks++;
        if (!ok || cyc != 3 * DIV_LAT + 3 || {rd, d} !== {5'd3, ref_result(OP_REM, 32'hFFFF_FFCE, 32'd7)}) begin
            errors++; $display("FAIL b2b_third cyc=%0d rd=%0d data=%h exp cyc=%0d rd=3 data=%h", cyc, rd, d, 3 * DIV_LAT + 3, ref_result(OP_REM, 32'hFFFF_FFCE, 32'd7));
        end
        @(posedge clk); #1; bus.overlap_ok_i = 1'b0; drive(1, OP_DIV, 5'd4, 32'd9, 32'd2);
        @(negedge clk);
        checks++;
        if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL nooverlap_first stall=%b exp=0", bus.stall_o); end
        @(posedge clk); #1; drive(1, OP_DIVU, 5'd5, 32'd8, 32'd2);
        @(negedge clk);
        checks++;
        if (bus.stall_o !== 1'b1) begin errors++; $display("FAIL nooverlap_stall stall=%b exp=1", bus.stall_o); end
        @(posedge clk); #1; drive(0, OP_DIV, 5'd0, 32'h0, 32'h0); bus.overlap_ok_i = 1'b1;
        cnt = 0; done = 0; rd = 0; d = 0;
        for (int c = 0; c < DIV_LAT + 10 && !done; c++) begin
            @(negedge clk);
            if (bus.wb_valid_o === 1'b1) begin cnt++; rd = bus.wb_rd_o; d = bus.wb_data_o; end
            if (bus.busy_o === 1'b0) done = 1;
        end
        checks++;
        if (!done || cnt != 1 || {rd, d} !== {5'd4, 32'd4}) begin
            errors++; $display("FAIL nooverlap_drain done=%0d results=%0d rd=%0d data=%h exp 1 1 rd=4 data=4", done, cnt, rd, d);
        end
    endtask

    task automatic test_hold;
        logic [4:0]  h_rd, rd;
        logic [31:0] h_d, d;
        bit seen, ok;
        int n;
        bus.overlap_ok_i = 1'b1; bus.wb_ready_i = 1'b0; bus.flush_i = 1'b0;
        @(posedge clk); #1; drive(1, OP_DIV, 5'd6, 32'd200, 32'd9);
        @(posedge clk); #1; drive(1, OP_DIVU, 5'd7, 32'd1000, 32'd10);
        @(posedge clk); #1; drive(0, OP_DIV, 5'd0, 32'h0, 32'h0);
        seen = 0; h_rd = 0; h_d = 0;
        for (int c = 0; c < DIV_LAT + 5 && !seen; c++) begin
            @(negedge clk);
            if (bus.wb_valid_o === 1'b1) begin seen = 1; h_rd = bus.wb_rd_o; h_d = bus.wb_data_o; end
        end
        checks++;
        if (!seen || {h_rd, h_d} !== {5'd6, 32'd22}) begin
            errors++; $display("FAIL hold_first seen=%0d rd=%0d data=%h exp rd=6 data=%h", seen, h_rd, h_d, 32'd22);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if ({bus.wb_valid_o, bus.div_start_o, bus.wb_rd_o, bus.wb_data_o} !== {2'b10, h_rd, h_d}) begin
                errors++; $display("FAIL hold_stable c=%0d valid=%b start=%b rd=%0d data=%h exp 1 0 rd=%0d data=%h",
                                   c, bus.wb_valid_o, bus.div_start_o, bus.wb_rd_o, bus.wb_data_o, h_rd, h_d);
            end
        end
        @(posedge clk); #1; bus.wb_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({bus.div_start_o, bus.wb_valid_o, bus.div_signed_o, bus.div_a_o, bus.div_b_o} !== {3'b100, 32'd1000, 32'd10}) begin
            errors++; $display("FAIL hold_pending_start start=%b valid=%b sgn=%b a=%h b=%h exp 1 0 0 a=%h b=%h",
                               bus.div_start_o, bus.wb_valid_o, bus.div_signed_o, bus.div_a_o, bus.div_b_o, 32'd1000, 32'd10);
        end
        wait_wb(DIV_LAT + 5, n, rd, d, ok);
        checks++;
        if (!ok || n != DIV_LAT || {rd, d} !== {5'd7, 32'd100}) begin
            errors++; $display("FAIL hold_second n=%0d rd=%0d data=%h exp n=%0d rd=7 data=%h", n, rd, d, DIV_LAT, 32'd100);
        end
        @(negedge clk);
    endtask

    task automatic test_flush;
        logic [4:0]  rd;
        logic [31:0] d;
        bit ok;
        int n, extra;
        bus.overlap_ok_i = 1'b1; bus.wb_ready_i = 1'b1; bus.flush_i = 1'b0;
        @(posedge clk); #1; drive(1, OP_DIV, 5'd8, 32'd12345, 32'd11);
        @(posedge clk); #1; drive(1, OP_REMU, 5'd9, 32'd99, 32'd4);
        @(posedge clk); #1; drive(0, OP_DIV, 5'd0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1; drive(1, OP_DIV, 5'd10, 32'd50, 32'd5); bus.flush_i = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.stall_o, bus.busy_o} !== 2'b01) begin errors++; $display("FAIL flush_cycle stall=%b busy=%b exp 0 1", bus.stall_o, bus.busy_o); end
        @(posedge clk); #1; drive(0, OP_DIV, 5'd0, 32'h0, 32'h0); bus.flush_i = 1'b0;
        wait_wb(DIV_LAT + 5, n, rd, d, ok);
        checks++;
        if (!ok || {rd, d} !== {5'd8, 32'd1122}) begin
            errors++; $display("FAIL flush_inflight ok=%0d rd=%0d data=%h exp rd=8 data=%h", ok, rd, d, 32'd1122);
        end
        extra = 0;
        for (int c = 0; c < 2 * DIV_LAT + 5; c++) begin
            @(negedge clk);
            if (bus.wb_valid_o !== 1'b0 || bus.div_start_o !== 1'b0 || bus.busy_o !== 1'b0) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL flush_dropped activity_cycles=%0d exp=0", extra); end
    endtask

    task automatic test_reset_mid;
        bus.overlap_ok_i = 1'b1; bus.wb_ready_i = 1'b1; bus.flush_i = 1'b0;
        @(posedge clk); #1; drive(1, OP_DIV, 5'd11, 32'd1000, 32'd7);
        @(posedge clk); #1; drive(0, OP_DIV, 5'd0, 32'h0, 32'h0);
        repeat (9) @(posedge clk);
        #1; drive(1, OP_DIVU, 5'd12, 32'd5, 32'd1); bus.overlap_ok_i = 1'b0;
        #1;
        checks++;
        if ({bus.stall_o, bus.div_a_o} !== {1'b1, 32'd1000}) begin
            errors++; $display("FAIL midrun_pre stall=%b a=%h exp 1 a=%h", bus.stall_o, bus.div_a_o, 32'd1000);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 106'h0) begin errors++; $display("FAIL midrun_reset got=%h exp=0", all_outs()); end
        drive(0, OP_DIV, 5'd0, 32'h0, 32'h0); bus.overlap_ok_i = 1'b1;
        @(negedge clk); rst = 1'b1;
        bus.wb_ready_i = 1'b0;
        @(posedge clk); #1; drive(1, OP_REMU, 5'd13, 32'd5, 32'd0);
        @(posedge clk); #1; drive(0, OP_DIV, 5'd0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if ({bus.wb_valid_o, bus.wb_rd_o, bus.wb_data_o} !== {1'b1, 5'd13, 32'd5}) begin
            errors++; $display("FAIL middone_pre valid=%b rd=%0d data=%h exp 1 13 5", bus.wb_valid_o, bus.wb_rd_o, bus.wb_data_o);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (all_outs() !== 106'h0) begin errors++; $display("FAIL middone_reset got=%h exp=0", all_outs()); end
        @(negedge clk); rst = 1'b1; bus.wb_ready_i = 1'b1;
        run_op(OP_DIVU, 5'd14, 32'd9, 32'd3, DIV_LAT + 1, 32'd3, "post_reset");
    endtask

    task automatic test_random;
        exp_t q[$];
        exp_t e;
        bit have, exp_stall, done;
        logic [1:0]  op;
        logic [4:0]  rd;
        logic [31:0] a, b;
        int sel;
        have = 0; op = 0; rd = 0; a = 0; b = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(posedge clk); #1;
            if (!have && $urandom_range(0, 2) == 0) begin
                have = 1;
                op   = 2'($urandom_range(0, 3));
                rd   = 5'($urandom_range(0, 31));
                sel  = $urandom_range(0, 9);
                a    = $urandom;
                b    = $urandom;
                if (sel == 0) b = 32'h0;
                else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                else if (sel < 5) b = 32'($urandom_range(1, 100));
            end
            bus.overlap_ok_i = ($urandom_range(0, 3) != 0);
            bus.flush_i      = ($urandom_range(0, 24) == 0);
            bus.wb_ready_i   = ($urandom_range(0, 3) != 0);
            drive(have, op, rd, a, b);
            @(negedge clk);
            exp_stall = have && !bus.flush_i && q.size() > 0 && (q.size() == 2 || !bus.overlap_ok_i);
            checks++;
            if (bus.stall_o !== exp_stall) begin errors++; $display("FAIL rand_stall cyc=%0d got=%b exp=%b", cyc, bus.stall_o, exp_stall); end
            checks++;
            if (bus.busy_o !== (q.size() > 0)) begin errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, bus.busy_o, q.size() > 0); end
            if (bus.flush_i && q.size() == 2) e = q.pop_back();
            if (bus.wb_valid_o === 1'b1 && bus.wb_ready_i) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious cyc=%0d rd=%0d data=%h exp no result", cyc, bus.wb_rd_o, bus.wb_data_o);
                end else begin
                    e = q.pop_front();
                    if ({bus.wb_rd_o, bus.wb_data_o} !== {e.rd, e.data}) begin
                        errors++; $display("FAIL rand_result cyc=%0d rd=%0d data=%h exp rd=%0d data=%h", cyc, bus.wb_rd_o, bus.wb_data_o, e.rd, e.data);
                    end
                end
            end
            if (have && !bus.flush_i && !exp_stall) begin
                e.rd = rd; e.data = ref_result(op, a, b);
                q.push_back(e);
                have = 0;
            end
            if (bus.flush_i) have = 0;
        end
        @(posedge clk); #1;
        drive(0, OP_DIV, 5'd0, 32'h0, 32'h0); bus.flush_i = 1'b0; bus.wb_ready_i = 1'b1;
        done = 0;
        for (int c = 0; c < 3 * (DIV_LAT + 2) && !done; c++) begin
            @(negedge clk);
            if (bus.wb_valid_o === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_drain_spurious rd=%0d data=%h exp no result", bus.wb_rd_o, bus.wb_data_o);
                end else begin
                    e = q.pop_front();
                    if ({bus.wb_rd_o, bus.wb_data_o} !== {e.rd, e.data}) begin
                        errors++; $display("FAIL rand_drain_result rd=%0d data=%h exp rd=%0d data=%h", bus.wb_rd_o, bus.wb_data_o, e.rd, e.data);
                    end
                end
            end
            if (q.size() == 0 && bus.busy_o === 1'b0) done = 1;
        end
        checks++;
        if (!done || q.size() != 0) begin errors++; $display("FAIL rand_drain done=%0d left=%0d exp 1 0", done, q.size()); end
    endtask

    initial begin
        test_reset();
        test_div_rem();
        test_fast();
        test_back_to_back();
        test_hold();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_scheduler.md
DIV_SCHEDULER -- requirements
Module: div_scheduler

Interface
REQ-001 SHALL have parameter DIV_LAT, default 32: number of datapath cycles from div_start_o to a valid div_q_i/div_r_i (legal range 2..63).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port issue_valid_i, input, 1 bit: EX presents an M-extension divide/remainder op.
REQ-005 SHALL have port issue_op_i, input, 2 bits: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-006 SHALL have port issue_rd_i, input, 5 bits: destination register.
REQ-007 SHALL have ports issue_a_i and issue_b_i, input, 32 bits each: dividend and divisor.
REQ-008 SHALL have port overlap_ok_i, input, 1 bit: from ID; the new op is independent of the in-flight rd.
REQ-009 SHALL have port flush_i, input, 1 bit: kills younger (pending/issuing) ops.
REQ-010 SHALL have port stall_o, output, 1 bit: holds the front end; the issue is not accepted this cycle.
REQ-011 SHALL have port busy_o, output, 1 bit: state is not IDLE or the pending slot is valid.
REQ-012 SHALL have ports div_start_o and div_signed_o (output, 1 bit each) and div_a_o and div_b_o (output, 32 bits each), driving the iterative divider datapath.
REQ-013 SHALL have ports div_q_i and div_r_i, input, 32 bits each: datapath quotient and remainder, signed-corrected.
REQ-014 SHALL have ports wb_valid_o (output, 1 bit), wb_rd_o (output, 5 bits), wb_data_o (output, 32 bits) and wb_ready_i (input, 1 bit): valid/ready result port to the WB arbiter.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE, plus a single-entry pending slot (op, rd, a, b).
REQ-016 SHALL accept an issue when issue_valid_i=1 and stall_o=0; stall_o = issue_valid_i & ~flush_i & (state≠IDLE) & (pending valid | ~overlap_ok_i).
REQ-017 SHALL, on accepting an issue while in IDLE, start it directly; when not in IDLE, SHALL write it into the pending slot.
REQ-018 SHALL apply start semantics as follows: a fast case (b==0, or signed op with a=0x80000000 and b=0xFFFFFFFF) SHALL go to DONE with the result computed internally and no div_start_o; otherwise SHALL go to RUN with the operands registered onto div_a_o/div_b_o.
REQ-019 SHALL pulse div_start_o for exactly one cycle, in the first RUN cycle; div_signed_o SHALL be 1 for DIV/REM and SHALL remain stable through RUN.
REQ-020 SHALL, in RUN, load a counter with DIV_LAT-1 and decrement it each cycle; at count 0 it SHALL capture div_q_i (DIV/DIVU) or div_r_i (REM/REMU) into the result register and enter DONE.
REQ-021 SHALL produce fast-case results as follows: b==0 gives quotient 0xFFFFFFFF and remainder a; signed overflow gives quotient 0x80000000 and remainder 0.
REQ-022 SHALL set latency as follows: normal ops assert wb_valid_o DIV_LAT+1 cycles after acceptance; fast ops assert it 1 cycle after.
REQ-023 SHALL drive wb_valid_o = (state==DONE); wb_rd_o and wb_data_o SHALL be held stable until wb_ready_i=1.
REQ-024 SHALL, in DONE with wb_ready_i=1, start the pending op if one is valid (clearing the slot); else start an issue accepted in the same cycle; else return to IDLE.
REQ-025 SHALL, on flush_i=1, invalidate the pending slot and refuse the concurrent issue; the in-flight RUN/DONE op (older) SHALL complete normally.
REQ-026 SHALL pass rd=0 ops normally (the WB stage discards the write).

Reset
REQ-027 SHALL, with rst=0, force state IDLE, pending invalid and counter 0, and drive every output to 0, asynchronously, including mid-RUN or mid-DONE.
REQ-028 SHALL, after rst returns to 1, accept the first issue in the following cycle, with no residual result.

Verification
REQ-029 SHALL cover this case: DIV_LAT=32, DIV a=100 b=7 rd=5 accepted at cycle 0 -> div_start_o at cycle 1, wb_valid_o at cycle 33 with rd 5 and data 14; REM of the same operands -> data 2.
REQ-030 SHALL cover this case: DIVU 5/0 -> wb_valid_o at cycle 1 with data 0xFFFFFFFF, and div_start_o never asserts; REMU 5/0 -> data 5.
REQ-031 SHALL cover this case: DIV 0x80000000/0xFFFFFFFF -> data 0x80000000 in 1 cycle; REM of the same operands -> data 0.
REQ-032 SHALL cover this case: three back-to-back divs with overlap_ok_i=1 -> the 1st runs, the 2nd is pending with stall_o=0, and the 3rd sees stall_o=1 until the 1st retires; with overlap_ok_i=0, the 2nd stalls.
REQ-033 SHALL cover this case: wb_ready_i held at 0 for 10 cycles in DONE -> wb_rd_o and wb_data_o are unchanged and the pending op does not start; ready=1 -> the pending op starts the next cycle.
REQ-034 SHALL cover this case: flush_i during RUN with the pending slot valid -> pending dropped and the in-flight result still delivered; rst=0 at RUN cycle 10 -> all outputs 0 immediately.
